// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: words, I-cache address decode, frame and FSM state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int IIDX_W      = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 30 - IIDX_W;

    // Fetch address split for the default 16-frame instruction cache
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-block instruction cache with miss fill FSM
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic [31:0]      imemload,
    output logic             ihit,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic [31:0]      iload,
    input  logic             iwait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    // Same layout as icache_frame_t, but sized from this instance's SETS
    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        word_t         data;
    } frame_t;

    frame_t        frames [SETS];
    icache_state_t state;
    icache_state_t next_state;
    logic [29:0]   miss_addr;   // {tag, idx} of the word being filled

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic          miss_start;
    logic          fill_done;
    logic          unused_bytoff;

    assign idx           = imemaddr[2 +: IW];
    assign tag           = imemaddr[31 -: TW];
    assign unused_bytoff = ^imemaddr[1:0];

    // Lookup only depends on stored frames and the fetch address, never on iload/iwait
    assign hit = imemREN && frames[idx].valid && (frames[idx].tag == tag);

    // Frame storage: fill overwrites the missed frame unconditionally
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else if (fill_done) begin
            frames[miss_addr[IW-1:0]] <= {1'b1, miss_addr[29 -: TW], iload};
        end
    end

    // FSM state and latched miss address
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_addr <= imemaddr[31:2];
            end
        end
    end

    // Next-state and outputs; FETCH holds the request until memory drops iwait
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                ihit = hit;
                if (hit) begin
                    imemload = frames[idx].data;
                end
                if (imemREN && !hit) begin
                    miss_start = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bring-up counters, wrapping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_start) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct with a word-address cache model
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic        iwait = 1'b1;
    logic [31:0] imemaddr = '0;
    logic [31:0] iload = '0;

    logic [31:0] imemload, iaddr, hit_count, miss_count;
    logic        ihit, iREN;
    logic [31:0] imemload4, iaddr4;
    logic        ihit4, iREN4;
    logic [3:0]  hit_count4, miss_count4;

    int compared = 0;
    int mismatched = 0;

    icache_direct #(.SETS(16), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .imemload(imemload), .ihit(ihit), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait), .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_direct #(.SETS(16), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .imemload(imemload4), .ihit(ihit4), .iREN(iREN4), .iaddr(iaddr4),
        .iload(iload), .iwait(iwait), .hit_count(hit_count4), .miss_count(miss_count4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each line remembers the full word address it holds
    logic        m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    logic        m_filling = 1'b0;
    logic [29:0] m_fill = '0;
    logic [31:0] m_hits = '0;
    logic [31:0] m_misses = '0;

    // Compare process: outputs are checked mid-cycle, then the model advances past the next edge
    always @(negedge CLK) begin
        logic        e_hit, e_ren;
        logic [31:0] e_load, e_addr;
        int          k;
        if (RST) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_filling = 1'b0;
            m_hits    = '0;
            m_misses  = '0;
        end
        k      = int'(imemaddr[5:2]);
        e_hit  = 1'b0;
        e_ren  = 1'b0;
        e_load = '0;
        e_addr = '0;
        if (!RST) begin
            if (m_filling) begin
                e_ren  = 1'b1;
                e_addr = {m_fill, 2'b00};
            end else if (imemREN && m_valid[k] && m_word[k] == imemaddr[31:2]) begin
                e_hit  = 1'b1;
                e_load = m_data[k];
            end
        end
        chk("ihit", {31'd0, ihit}, {31'd0, e_hit});
        chk("imemload", imemload, e_load);
        chk("iREN", {31'd0, iREN}, {31'd0, e_ren});
        chk("iaddr", iaddr, e_addr);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
        chk("ihit_c4", {31'd0, ihit4}, {31'd0, e_hit});
        chk("iaddr_c4", iaddr4, e_addr);
        chk("hit_count_c4", {28'd0, hit_count4}, {28'd0, m_hits[3:0]});
        chk("miss_count_c4", {28'd0, miss_count4}, {28'd0, m_misses[3:0]});
        if (!RST) begin
            if (m_filling) begin
                if (!iwait) begin
                    m_valid[m_fill[3:0]] = 1'b1;
                    m_word[m_fill[3:0]]  = m_fill;
                    m_data[m_fill[3:0]]  = iload;
                    m_filling = 1'b0;
                end
            end else if (e_hit) begin
                m_hits = m_hits + 32'd1;
            end else if (imemREN) begin
                m_misses  = m_misses + 32'd1;
                m_filling = 1'b1;
                m_fill    = imemaddr[31:2];
            end
        end
    end

    task automatic drive(input logic ren, input logic [31:0] a, input logic w, input logic [31:0] d);
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = d;
    endtask

    task automatic look();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        imemREN = 1'b0;
        iwait   = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, 1'b1, 32'd0);
        drive(1'b1, a, 1'b0, d);
    endtask

    initial begin
        logic [31:0] a;
        // reset state
        look();
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        do_reset();

        // cold miss: 3 wait cycles then data
        drive(1'b1, 32'h40, 1'b1, 32'd0);
        drive(1'b1, 32'h40, 1'b1, 32'd0);
        look();
        chk("cold_iREN", {31'd0, iREN}, 32'd1);
        chk("cold_iaddr", iaddr, 32'h40);
        drive(1'b1, 32'h40, 1'b1, 32'd0);
        drive(1'b1, 32'h40, 1'b1, 32'd0);
        drive(1'b1, 32'h40, 1'b0, 32'h2008_0005);
        look();
        chk("cold_iaddr_last", iaddr, 32'h40);
        drive(1'b1, 32'h40, 1'b1, 32'd0);
        look();
        chk("cold_hit", {31'd0, ihit}, 32'd1);
        chk("cold_load", imemload, 32'h2008_0005);
        chk("cold_miss_count", miss_count, 32'd1);
        chk("cold_iREN_off", {31'd0, iREN}, 32'd0);

        // hit stream over 0x00..0x3C
        do_reset();
        for (int i = 0; i < 16; i++) fill(32'(i * 4), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 32'd0);
            look();
            chk("stream_hit", {31'd0, ihit}, 32'd1);
            chk("stream_load", imemload, 32'h1000_0000 + 32'(i));
        end
        drive(1'b0, 32'd0, 1'b1, 32'd0);
        look();
        chk("stream_hit_count", hit_count, 32'd16);
        chk("stream_miss_count", miss_count, 32'd16);

        // conflict on index 0
        do_reset();
        fill(32'h0, 32'hAAAA_0000);
        fill(32'h40, 32'hBBBB_0040);
        drive(1'b1, 32'h0, 1'b1, 32'd0);
        look();
        chk("conflict_miss", {31'd0, ihit}, 32'd0);
        drive(1'b1, 32'h0, 1'b0, 32'hAAAA_0001);
        look();
        chk("conflict_miss_count", miss_count, 32'd3);

        // redirect mid-fill
        do_reset();
        drive(1'b1, 32'h80, 1'b1, 32'd0);
        drive(1'b1, 32'h04, 1'b1, 32'd0);
        look();
        chk("redir_iaddr", iaddr, 32'h80);
        drive(1'b1, 32'h04, 1'b0, 32'hCAFE_0080);
        look();
        chk("redir_iaddr_hold", iaddr, 32'h80);
        drive(1'b1, 32'h04, 1'b1, 32'd0);
        look();
        chk("redir_new_miss", {31'd0, ihit}, 32'd0);
        drive(1'b1, 32'h04, 1'b1, 32'd0);
        look();
        chk("redir_new_iaddr", iaddr, 32'h04);
        drive(1'b1, 32'h04, 1'b0, 32'hCAFE_0004);
        drive(1'b1, 32'h80, 1'b1, 32'd0);
        look();
        chk("redir_old_hit", {31'd0, ihit}, 32'd1);
        chk("redir_old_load", imemload, 32'hCAFE_0080);

        // reset mid-fill
        drive(1'b1, 32'hC0, 1'b1, 32'd0);
        drive(1'b1, 32'hC0, 1'b1, 32'd0);
        look();
        chk("rstfill_iREN_before", {31'd0, iREN}, 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("rstfill_iREN_async", {31'd0, iREN}, 32'd0);
        chk("rstfill_hit_count", hit_count, 32'd0);
        chk("rstfill_miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        imemREN = 1'b0;
        drive(1'b1, 32'h80, 1'b1, 32'd0);
        look();
        chk("rstfill_cleared", {31'd0, ihit}, 32'd0);
        drive(1'b1, 32'h80, 1'b0, 32'h1234_5678);
        look();
        chk("rstfill_miss_count_after", miss_count, 32'd1);

        // 4-bit counter wrap
        do_reset();
        fill(32'h0, 32'h0BAD_F00D);
        repeat (17) drive(1'b1, 32'h0, 1'b1, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'd0);
        look();
        chk("wrap_hit_count_c4", {28'd0, hit_count4}, 32'd1);
        chk("wrap_hit_count", hit_count, 32'd17);

        // randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge CLK);
            #1;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a[31:28] = 4'($urandom_range(0, 15));
            RST      = ($urandom_range(0, 299) == 0);
            imemREN  = ($urandom_range(0, 4) != 0);
            imemaddr = a;
            iwait    = ($urandom_range(0, 1) == 0);
            iload    = $urandom;
        end
        do_reset();
        look();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
